pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/pipelined_barrel_shifter.sv | 144 ++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Two-stage barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake on both sides.
// S1 applies the upper half of the shift amount, S2 the lower half plus carry/zero.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam int LOW = SHW / 2;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    // Every mode composes additively, so hi-then-lo equals a single full shift.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input logic [SHW-1:0]   amt,
        input logic [1:0]       mode
    );
        logic [WIDTH-1:0] r;
        case (mode)
            MODE_SLL: r = d << amt;
            MODE_SRL: r = d >> amt;
            MODE_SRA: r = $signed(d) >>> amt;
            default:  r = (d >> amt) | (d << (WIDTH - int'(amt)));
        endcase
        return r;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_part_q,  s1_part_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [SHW-1:0]   s1_shamt_q, s1_shamt_d;
    logic [1:0]       s1_mode_q,  s1_mode_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_carry_q, out_carry_d;
    logic             out_zero_q, out_zero_d;

    logic             s2_adv;
    logic [SHW-1:0]   amt_hi;
    logic [SHW-1:0]   amt_lo;
    logic [SHW-1:0]   shamt_m1;
    logic [WIDTH-1:0] s2_res;
    logic [WIDTH-1:0] shl_probe;
    logic [WIDTH-1:0] shr_probe;
    logic             carry_calc;

    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        in_ready = reset && (!s1_valid_q || s2_adv);

        s1_valid_d = s1_valid_q;
        s1_part_d  = s1_part_q;
        s1_data_d  = s1_data_q;
        s1_shamt_d = s1_shamt_q;
        s1_mode_d  = s1_mode_q;

        amt_hi = {in_shamt[SHW-1:LOW], {LOW{1'b0}}};
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_part_d  = shift_by(in_data, amt_hi, in_mode);
                s1_data_d  = in_data;
                s1_shamt_d = in_shamt;
                s1_mode_d  = in_mode;
            end
        end

        amt_lo    = {{(SHW-LOW){1'b0}}, s1_shamt_q[LOW-1:0]};
        s2_res    = shift_by(s1_part_q, amt_lo, s1_mode_q);
        // Carry is the last bit to leave: probe the operand shifted by shamt-1.
        shamt_m1  = s1_shamt_q - SHW'(1);
        shl_probe = s1_data_q << shamt_m1;
        shr_probe = s1_data_q >> shamt_m1;
        if (s1_shamt_q == '0) begin
            carry_calc = 1'b0;
        end else begin
            case (s1_mode_q)
                MODE_SLL: carry_calc = shl_probe[WIDTH-1];
                MODE_SRL: carry_calc = shr_probe[0];
                MODE_SRA: carry_calc = shr_probe[0];
                default:  carry_calc = s2_res[WIDTH-1];
            endcase
        end

        s2_valid_d  = s2_valid_q;
        out_data_d  = out_data_q;
        out_carry_d = out_carry_q;
        out_zero_d  = out_zero_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d  = s2_res;
                out_carry_d = carry_calc;
                out_zero_d  = (s2_res == '0);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_part_q   <= '0;
            s1_data_q   <= '0;
            s1_shamt_q  <= '0;
            s1_mode_q   <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_part_q   <= s1_part_d;
            s1_data_q   <= s1_data_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_carry_q <= out_carry_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter: 32-bit main instance plus 8/16/64-bit sweep instances.
module tb_pipelined_barrel_shifter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_carry;
    logic        out_zero;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    pipelined_barrel_shifter #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero)
    );

    logic [63:0] sw_data = '0;
    logic [5:0]  sw_shamt = '0;
    logic [1:0]  sw_mode = '0;
    logic [2:0]  sw_valid = '0;
    logic [2:0]  sw_iready;
    logic [2:0]  sw_ovalid;
    logic [2:0]  sw_carry;
    logic [2:0]  sw_zero;
    logic [7:0]  o8_data;
    logic [15:0] o16_data;
    logic [63:0] o64_data;

    pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(sw_valid[0]), .in_ready(sw_iready[0]),
        .in_data(sw_data[7:0]), .in_shamt(sw_shamt[2:0]), .in_mode(sw_mode),
        .out_valid(sw_ovalid[0]), .out_ready(1'b1),
        .out_data(o8_data), .out_carry(sw_carry[0]), .out_zero(sw_zero[0])
    );
    pipelined_barrel_shifter #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset),
        .in_valid(sw_valid[1]), .in_ready(sw_iready[1]),
        .in_data(sw_data[15:0]), .in_shamt(sw_shamt[3:0]), .in_mode(sw_mode),
        .out_valid(sw_ovalid[1]), .out_ready(1'b1),
        .out_data(o16_data), .out_carry(sw_carry[1]), .out_zero(sw_zero[1])
    );
    pipelined_barrel_shifter #(.WIDTH(64)) dut64 (
        .clock(clock), .reset(reset),
        .in_valid(sw_valid[2]), .in_ready(sw_iready[2]),
        .in_data(sw_data), .in_shamt(sw_shamt), .in_mode(sw_mode),
        .out_valid(sw_ovalid[2]), .out_ready(1'b1),
        .out_data(o64_data), .out_carry(sw_carry[2]), .out_zero(sw_zero[2])
    );

    task automatic drive(input logic [1:0] m, input logic [4:0] sh, input logic [31:0] d);
        in_valid = 1'b1;
        in_mode  = m;
        in_shamt = sh;
        in_data  = d;
    endtask

    task automatic test_reset;
        @(negedge clock);
        @(negedge clock);
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (out_data !== 32'h0) $display("FAIL rst_out_data: got %h want 0", out_data); else passed++;
        checks++; if ({out_carry, out_zero} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {out_carry, out_zero}); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_sra;
        @(negedge clock);
        out_ready = 1'b1;
        drive(2'b10, 5'd4, 32'h8000_0010);
        @(posedge clock); @(negedge clock);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL sra_early_valid: got %b want 0", out_valid); else passed++;
        @(posedge clock); @(negedge clock);
        checks++; if (out_valid !== 1'b1) $display("FAIL sra_valid: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== 32'hF800_0001) $display("FAIL sra_data: got %h want f8000001", out_data); else passed++;
        checks++; if ({out_carry, out_zero} !== 2'b00) $display("FAIL sra_flags: got %b want 00", {out_carry, out_zero}); else passed++;
    endtask

    task automatic test_back_to_back;
        drive(2'b00, 5'd31, 32'h0000_0001);
        @(posedge clock); @(negedge clock);
        drive(2'b01, 5'd1, 32'h0000_0001);
        @(posedge clock); @(negedge clock);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid0: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== 32'h8000_0000) $display("FAIL b2b_data0: got %h want 80000000", out_data); else passed++;
        checks++; if ({out_carry, out_zero} !== 2'b00) $display("FAIL b2b_flags0: got %b want 00", {out_carry, out_zero}); else passed++;
        @(posedge clock); @(negedge clock);
        checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid1: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== 32'h0) $display("FAIL b2b_data1: got %h want 00000000", out_data); else passed++;
        checks++; if ({out_carry, out_zero} !== 2'b11) $display("FAIL b2b_flags1: got %b want 11", {out_carry, out_zero}); else passed++;
        @(posedge clock); @(negedge clock);
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_ror;
        drive(2'b11, 5'd1, 32'h0000_0001);
        @(posedge clock); @(negedge clock);
        drive(2'b11, 5'd0, 32'hDEAD_BEEF);
        @(posedge clock); @(negedge clock);
        in_valid = 1'b0;
        checks++; if (out_data !== 32'h8000_0000) $display("FAIL ror1_data: got %h want 80000000", out_data); else passed++;
        checks++; if ({out_carry, out_zero} !== 2'b10) $display("FAIL ror1_flags: got %b want 10", {out_carry, out_zero}); else passed++;
        @(posedge clock); @(negedge clock);
        checks++; if (out_data !== 32'hDEAD_BEEF) $display("FAIL ror0_data: got %h want deadbeef", out_data); else passed++;
        checks++; if ({out_carry, out_zero} !== 2'b00) $display("FAIL ror0_flags: got %b want 00", {out_carry, out_zero}); else passed++;
        @(posedge clock); @(negedge clock);
    endtask

    task automatic test_stall;
        logic [1:0]  sm[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [4:0]  ss[5] = '{5'd4, 5'd4, 5'd31, 5'd8, 5'd1};
        logic [31:0] sd[5] = '{32'h0000_0001, 32'h0000_00F0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hC000_0000};
        logic [31:0] ex[5] = '{32'h0000_0010, 32'h0000_000F, 32'hFFFF_FFFF, 32'h7812_3456, 32'h8000_0000};
        logic        ec[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int ii = 0;
        int oi = 0;
        int c = 0;
        logic saw_block = 1'b0;
        logic stalled_prev = 1'b0;
        logic [31:0] prev = '0;
        while (oi < 5 && c < 40) begin
            out_ready = !(c >= 3 && c <= 6);
            if (ii < 5) drive(sm[ii], ss[ii], sd[ii]);
            else in_valid = 1'b0;
            #1;
            if (!in_ready) saw_block = 1'b1;
            if (stalled_prev) begin
                checks++; if (out_valid !== 1'b1 || out_data !== prev)
                    $display("FAIL stall_hold c%0d: got v=%b %h want v=1 %h", c, out_valid, out_data, prev); else passed++;
            end
            if (out_valid && out_ready) begin
                checks++; if (out_data !== ex[oi] || out_carry !== ec[oi])
                    $display("FAIL stall_out%0d: got %h c=%b want %h c=%b", oi, out_data, out_carry, ex[oi], ec[oi]); else passed++;
                oi++;
            end
            stalled_prev = out_valid && !out_ready;
            prev = out_data;
            if (in_valid && in_ready) ii++;
            @(posedge clock); @(negedge clock);
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (oi != 5) $display("FAIL stall_count: got %0d results want 5", oi); else passed++;
        checks++; if (saw_block !== 1'b1) $display("FAIL stall_in_ready: in_ready never fell, want a 0"); else passed++;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_valid !== 1'b0) $display("FAIL stall_dup%0d: got out_valid %b want 0", k, out_valid); else passed++;
            @(posedge clock); @(negedge clock);
        end
    endtask

    task automatic test_reset_mid;
        drive(2'b00, 5'd3, 32'h0000_0001);
        @(posedge clock); @(negedge clock);
        drive(2'b01, 5'd2, 32'h0000_0100);
        @(posedge clock); @(negedge clock);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL mid_prefill: got out_valid %b want 1", out_valid); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (out_data !== 32'h0) $display("FAIL mid_out_data: got %h want 0", out_data); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready: got %b want 0", in_ready); else passed++;
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); @(negedge clock);
            checks++; if (out_valid !== 1'b0) $display("FAIL mid_stale%0d: got out_valid %b want 0", k, out_valid); else passed++;
        end
        drive(2'b00, 5'd1, 32'h0000_0005);
        @(posedge clock); @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock); @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_000A)
            $display("FAIL mid_recover: got v=%b %h want v=1 0000000a", out_valid, out_data); else passed++;
        @(posedge clock); @(negedge clock);
    endtask

    task automatic sweep_vec(input int w, input logic [1:0] m, input logic [5:0] sh,
                             input logic [63:0] d, input logic [63:0] e, input logic ec);
        logic [63:0] got;
        logic        gv, gc, gz;
        int          sel;
        sel = (w == 8) ? 0 : (w == 16) ? 1 : 2;
        sw_mode  = m;
        sw_shamt = sh;
        sw_data  = d;
        sw_valid = 3'b001 << sel;
        @(posedge clock); @(negedge clock);
        sw_valid = 3'b000;
        @(posedge clock); @(negedge clock);
        got = (sel == 0) ? {56'h0, o8_data} : (sel == 1) ? {48'h0, o16_data} : o64_data;
        gv = sw_ovalid[sel];
        gc = sw_carry[sel];
        gz = sw_zero[sel];
        checks++; if (gv !== 1'b1 || got !== e || gc !== ec || gz !== (e == 64'h0))
            $display("FAIL sweep_w%0d_m%0d_s%0d: got v=%b %h c=%b z=%b want v=1 %h c=%b z=%b",
                     w, m, sh, gv, got, gc, gz, e, ec, (e == 64'h0)); else passed++;
    endtask

    task automatic test_sweep;
        sweep_vec(8,  2'b10, 6'd7,  64'hFF, 64'hFF, 1'b1);
        sweep_vec(8,  2'b00, 6'd7,  64'h81, 64'h80, 1'b0);
        sweep_vec(8,  2'b11, 6'd3,  64'h96, 64'hD2, 1'b1);
        sweep_vec(8,  2'b01, 6'd7,  64'h96, 64'h01, 1'b0);
        sweep_vec(8,  2'b10, 6'd0,  64'h80, 64'h80, 1'b0);
        sweep_vec(16, 2'b10, 6'd15, 64'h8001, 64'hFFFF, 1'b0);
        sweep_vec(16, 2'b00, 6'd12, 64'h00F0, 64'h0000, 1'b1);
        sweep_vec(16, 2'b11, 6'd4,  64'h1234, 64'h4123, 1'b0);
        sweep_vec(16, 2'b01, 6'd15, 64'hFFFF, 64'h0001, 1'b1);
        sweep_vec(64, 2'b10, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        sweep_vec(64, 2'b00, 6'd63, 64'h3, 64'h8000_0000_0000_0000, 1'b1);
        sweep_vec(64, 2'b11, 6'd63, 64'h1, 64'h2, 1'b0);
        sweep_vec(64, 2'b01, 6'd33, 64'h8000_0000_0000_0000, 64'h0000_0000_4000_0000, 1'b0);
        sweep_vec(64, 2'b11, 6'd32, 64'h0123_4567_89AB_CDEF, 64'h89AB_CDEF_0123_4567, 1'b1);
    endtask

    initial begin
        test_reset();
        test_sra();
        test_back_to_back();
        test_ror();
        test_stall();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
